sprite_rom_arbiter: RTL
=======================

Name: sprite_rom_arbiter

Overview:
- Shares one synchronous sprite ROM (palette-index output) among up to NUM_REQ sprite renderers (Link, enemies, projectiles) in the VGA pixel domain.
- Grants at most one ROM read per clock using round-robin priority.
- Tracks each read through the ROM latency and returns the palette index to the requester that issued it.
- Drains in-flight reads and re-seeds priority at each frame start, so every frame begins from a deterministic arbitration state.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_W, 10, ROM address width
- DATA_W, 4, ROM data width (palette index)
- ROM_LAT, 1, ROM read latency in clocks (1..3)

Ports:
- vga_clk  in  1  pixel clock; all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- frame_start  in  1  one-cycle pulse at start of frame (vsync edge)
- req  in  NUM_REQ  per-requester read request, level-held until granted
- req_addr  in  NUM_REQ*ADDR_W  packed per-requester addresses; requester i uses slice [i*ADDR_W +: ADDR_W]
- gnt  out  NUM_REQ  one-hot grant, combinational, same cycle as accepted req
- rom_address  out  ADDR_W  address to ROM
- rom_q  in  DATA_W  ROM data, valid ROM_LAT cycles after address
- rsp_valid  out  NUM_REQ  one-hot response strobe
- rsp_data  out  DATA_W  palette index for the responding requester
- draining  out  1  high while in DRAIN state

Behaviour:
- Clock and reset: one clock (vga_clk); reset_n is asynchronous, active-low.
- Reset state:
  - state=RUN, rr_ptr=0, tag pipeline cleared.
  - gnt=0, rsp_valid=0, rsp_data=0, rom_address=0, draining=0.
- Arbitration (RUN only):
  - Search req starting at index rr_ptr, wrapping modulo NUM_REQ.
  - The first set bit i gets gnt[i]=1 in the same cycle.
  - rom_address=req_addr slice i.
  - rr_ptr <= (i+1) mod NUM_REQ at the clock edge.
  - No req set: gnt=0, rom_address holds its last value, rr_ptr unchanged.
- Handshake:
  - A requester holds req and addr stable until it sees gnt.
  - It may drop req, or present a new addr, the cycle after grant.
  - Dropping req before grant is legal; no read is issued for it.
- Tag pipeline:
  - ROM_LAT-deep shift register of one-hot tags; the stage 0 input is gnt.
  - rsp_valid = last stage.
  - rsp_data = rom_q when any rsp_valid bit is set, else 0.
  - Read granted in cycle t: rsp_valid[i] asserts in cycle t+ROM_LAT for exactly one cycle.
  - Back-to-back grants give back-to-back responses. Throughput is 1 read/clock.
- FSM:
  - RUN -> DRAIN on frame_start.
  - In DRAIN: gnt forced to 0, draining=1, in-flight tags keep shifting and their responses are still delivered.
  - DRAIN -> RUN once the tag pipeline is empty. The exit cycle sets rr_ptr <= 0.
  - Minimum DRAIN length is 1 cycle, even when the pipeline is already empty.
- Simultaneous events:
  - frame_start in the same cycle as a pending req: no grant that cycle; frame_start wins.
  - frame_start while in DRAIN: stays in DRAIN (no restart of the count).
- Reset mid-operation: in-flight tags are discarded. A response the ROM delivers after reset is never flagged.

Optional Feature:
- ARB_STATS_EN defined:
  - Adds output stall_max (8 bits): the largest number of consecutive cycles any single requester held req without gnt since the last frame_start.
  - Per-requester saturating 8-bit wait counters; stall_max saturates at 255.
  - stall_max clears on frame_start; resets to 0.
- ARB_STATS_EN undefined: no counters and no stall_max port; the rest of the behaviour is identical.

Decomposition:
- Shared package sprite_arb_pkg:
  - arb_state_t enum {RUN, DRAIN}
  - localparam defaults for ADDR_W/DATA_W matching the sprite ROM geometry (32x32 sprite, 1024 words, 4-bit index)
  - function rr_pick(req, ptr) returning the one-hot grant
- One sub-module: rr_arbiter, a pure combinational round-robin pick (req, rr_ptr -> gnt, granted index). The top keeps rr_ptr, FSM, tag pipeline and the optional stats.

Test Plan:
- Single requester, ROM_LAT=1: req=4'b0010, addr1=10'd37 -> gnt=4'b0010 same cycle, rom_address=37; next cycle rsp_valid=4'b0010, rsp_data=ROM[37].
- All four requesting continuously from reset -> grant order 0,1,2,3,0,1,...; each requester gets exactly one grant per 4 cycles.
- ROM_LAT=3, back-to-back grants to 2 then 3 -> rsp_valid 4'b0100 then 4'b1000 on cycles t+3 and t+4, data matching the respective addresses.
- frame_start one cycle after a grant to 1 (ROM_LAT=2), req=4'b1111 held:
  - draining=1 and gnt=0 while the response to requester 1 is still delivered;
  - after DRAIN exits, the first grant goes to 0.
- Assert reset_n low with 2 tags in flight (ROM_LAT=3) -> all outputs 0 immediately; no rsp_valid in the next 3 cycles after release with req=0.
- ARB_STATS_EN: requester 3 blocked for 3 cycles by requesters 0..2 -> stall_max=3; frame_start -> 0.

Source files
------------

// File: rtl/sprite_arb_pkg.sv
// rtl/sprite_arb_pkg.sv - shared types, sprite ROM geometry and round-robin pick for the sprite ROM arbiter
package sprite_arb_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } arb_state_t;

    // 32x32 sprite sheet: 1024 words of 4-bit palette index
    localparam int SPRITE_ADDR_W = 10;
    localparam int SPRITE_DATA_W = 4;
    localparam int MAX_REQ       = 8;

    function automatic logic [MAX_REQ-1:0] rr_pick(
        input logic [MAX_REQ-1:0] req,
        input logic [2:0]         ptr,
        input int unsigned        num_req
    );
        logic [MAX_REQ-1:0] pick;
        logic               found;
        logic [2:0]         idx;
        pick  = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            idx = 3'((32'(ptr) + k) % num_req);
            if (k < num_req && !found && req[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/sprite_rom_arbiter_rr.sv
// rtl/sprite_rom_arbiter_rr.sv - combinational round-robin pick returning one-hot grant and its index
module rr_arbiter
    import sprite_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx
);

    logic [MAX_REQ-1:0] req_ext;
    logic [MAX_REQ-1:0] pick;

    always_comb begin
        req_ext              = '0;
        req_ext[NUM_REQ-1:0] = req;
        pick                 = rr_pick(req_ext, 3'(rr_ptr), NUM_REQ);
        gnt                  = pick[NUM_REQ-1:0];
        gnt_idx              = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (pick[i]) gnt_idx = IDX_W'(i);
        end
    end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// rtl/sprite_rom_arbiter.sv - round-robin sprite ROM sharing with tagged responses and frame drain; ARB_STATS_EN adds stall_max
module sprite_rom_arbiter
    import sprite_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = SPRITE_ADDR_W,
    parameter int DATA_W  = SPRITE_DATA_W,
    parameter int ROM_LAT = 1
) (
    input  logic                      vga_clk,
    input  logic                      reset_n,
    input  logic                      frame_start,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [ADDR_W-1:0]         rom_address,
    input  logic [DATA_W-1:0]         rom_q,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      draining
`ifdef ARB_STATS_EN
    ,
    output logic [7:0]                stall_max
`endif
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_t           state;
    arb_state_t           state_next;
    logic [IDX_W-1:0]     rr_ptr;
    logic [IDX_W-1:0]     pick_idx;
    logic [NUM_REQ-1:0]   pick;
    logic [NUM_REQ-1:0]   tags [ROM_LAT];
    logic [ADDR_W-1:0]    addr_q;
    logic                 grant_en;
    logic                 pipe_empty;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req     (req),
        .rr_ptr  (rr_ptr),
        .gnt     (pick),
        .gnt_idx (pick_idx)
    );

    always_comb begin
        pipe_empty = 1'b1;
        for (int s = 0; s < ROM_LAT; s++) begin
            if (|tags[s]) pipe_empty = 1'b0;
        end
    end

    always_comb begin
        state_next = state;
        grant_en   = 1'b0;
        case (state)
            RUN: begin
                if (frame_start) state_next = DRAIN;
                else             grant_en   = 1'b1;
            end
            DRAIN: begin
                if (pipe_empty) state_next = RUN;
            end
            default: state_next = RUN;
        endcase
    end

    // Gated by reset_n so a held request cannot leak a grant while in reset
    assign gnt         = (grant_en && reset_n) ? pick : '0;
    assign rom_address = (|gnt) ? req_addr[pick_idx*ADDR_W +: ADDR_W] : addr_q;
    assign rsp_valid   = tags[ROM_LAT-1];
    assign rsp_data    = (|rsp_valid) ? rom_q : '0;
    assign draining    = (state == DRAIN);

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= RUN;
            rr_ptr <= '0;
            addr_q <= '0;
            for (int s = 0; s < ROM_LAT; s++) tags[s] <= '0;
        end else begin
            state   <= state_next;
            tags[0] <= gnt;
            for (int s = 1; s < ROM_LAT; s++) tags[s] <= tags[s-1];
            if (|gnt) begin
                addr_q <= rom_address;
                rr_ptr <= (pick_idx == IDX_W'(NUM_REQ-1)) ? '0 : pick_idx + 1'b1;
            end else if (state == DRAIN && state_next == RUN) begin
                rr_ptr <= '0;
            end
        end
    end

`ifdef ARB_STATS_EN
    logic [7:0] wait_cnt  [NUM_REQ];
    logic [7:0] wait_next [NUM_REQ];
    logic [7:0] wait_peak;

    always_comb begin
        wait_peak = stall_max;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req[i] && !gnt[i])
                wait_next[i] = (wait_cnt[i] == 8'hFF) ? 8'hFF : wait_cnt[i] + 8'd1;
            else
                wait_next[i] = 8'd0;
            if (wait_next[i] > wait_peak) wait_peak = wait_next[i];
        end
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_max <= 8'd0;
            for (int i = 0; i < NUM_REQ; i++) wait_cnt[i] <= 8'd0;
        end else if (frame_start) begin
            stall_max <= 8'd0;
            for (int i = 0; i < NUM_REQ; i++) wait_cnt[i] <= 8'd0;
        end else begin
            stall_max <= wait_peak;
            for (int i = 0; i < NUM_REQ; i++) wait_cnt[i] <= wait_next[i];
        end
    end
`endif

endmodule
